// File: rtl/requantize_pipe.sv
// requantize_pipe: three-stage requantizer from signed accumulator values to
// unsigned OUT_W-bit activations. Scale, shift and zero point are per-channel
// runtime parameters. Rounding is optional, results are clipped to the output
// range, flow control is valid/ready, and a saturating counter tallies clips.
module requantize_pipe #(
    parameter int IN_W     = 32,
    parameter int OUT_W    = 8,
    parameter int MULT_W   = 32,
    parameter int SHIFT_W  = 6,
    parameter int CHANNELS = 4,
    parameter int ROUND    = 1,
    parameter int CNT_W    = 16,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [IN_W-1:0]     in_data,
    input  logic        [CH_W-1:0]     in_ch,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic        [OUT_W-1:0]    out_data,
    output logic        [CH_W-1:0]     out_ch,
    output logic                       out_sat,
    input  logic                       cfg_we,
    input  logic        [CH_W-1:0]     cfg_ch,
    input  logic        [MULT_W-1:0]   cfg_mult,
    input  logic        [SHIFT_W-1:0]  cfg_shift,
    input  logic        [OUT_W-1:0]    cfg_zp,
    input  logic                       sat_clr,
    output logic        [CNT_W-1:0]    sat_count
);

    // Product width holds in_data * zero-extended M exactly. One extra bit
    // absorbs the rounding constant, and another holds the zero-point add.
    localparam int PW = IN_W + MULT_W + 1;
    localparam int RW = PW + 1;
    localparam int QW = RW + 1;

    // Number of table entries, in a width that also holds the value CHANNELS.
    localparam logic [CH_W:0] CH_LIMIT = (CH_W + 1)'(CHANNELS);

    // True when a channel index addresses a real table entry.
    function automatic logic ch_in_range(input logic [CH_W-1:0] ch);
        return ({1'b0, ch} < CH_LIMIT);
    endfunction

    // Per-channel parameter table.
    logic [MULT_W-1:0]  mult_tab_r  [CHANNELS];
    logic [SHIFT_W-1:0] shift_tab_r [CHANNELS];
    logic [OUT_W-1:0]   zp_tab_r    [CHANNELS];

    // Stage 1: captured input beat and its channel parameters.
    logic                     s1_valid_r;
    logic signed [IN_W-1:0]   s1_data_r;
    logic [CH_W-1:0]          s1_ch_r;
    logic [MULT_W-1:0]        s1_mult_r;
    logic [SHIFT_W-1:0]       s1_shift_r;
    logic [OUT_W-1:0]         s1_zp_r;

    // Stage 2: full-precision product.
    logic                     s2_valid_r;
    logic signed [PW-1:0]     s2_prod_r;
    logic [CH_W-1:0]          s2_ch_r;
    logic [SHIFT_W-1:0]       s2_shift_r;
    logic [OUT_W-1:0]         s2_zp_r;

    // Stage 3: output register.
    logic                     out_valid_r;
    logic [OUT_W-1:0]         out_data_r;
    logic [CH_W-1:0]          out_ch_r;
    logic                     out_sat_r;
    logic [CNT_W-1:0]         sat_count_r;

    logic                     en_s;
    logic [CH_W-1:0]          rd_idx_s;
    logic signed [PW-1:0]     prod_s;
    logic signed [RW-1:0]     rnd_s;
    logic signed [RW-1:0]     sum_s;
    logic signed [RW-1:0]     shr_s;
    logic signed [QW-1:0]     q_s;
    logic [OUT_W-1:0]         sat_data_s;
    logic                     sat_s;

    // The whole pipeline advances together. It moves when the output slot is
    // empty or is being drained.
    always_comb begin
        en_s = !out_valid_r || out_ready;
    end

    assign in_ready  = en_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign out_sat   = out_sat_r;
    assign sat_count = sat_count_r;

    // Beats on a non-existent channel fall back to entry 0.
    always_comb begin
        if (ch_in_range(in_ch)) begin
            rd_idx_s = in_ch;
        end else begin
            rd_idx_s = '0;
        end
    end

    // Parameter table writes. Writes ignore the stall state. A write lands
    // at the same edge that a beat samples the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                mult_tab_r[i]  <= '0;
                shift_tab_r[i] <= '0;
                zp_tab_r[i]    <= '0;
            end
        end else if (cfg_we && ch_in_range(cfg_ch)) begin
            mult_tab_r[cfg_ch]  <= cfg_mult;
            shift_tab_r[cfg_ch] <= cfg_shift;
            zp_tab_r[cfg_ch]    <= cfg_zp;
        end
    end

    // Valid bits ripple one stage per enabled cycle. Bubbles are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s2_valid_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (en_s) begin
            s1_valid_r  <= in_valid;
            s2_valid_r  <= s1_valid_r;
            out_valid_r <= s2_valid_r;
        end
    end

    // Stage 1: latch the beat along with a snapshot of its channel's
    // parameters, so later writes cannot affect beats already in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_r  <= '0;
            s1_ch_r    <= '0;
            s1_mult_r  <= '0;
            s1_shift_r <= '0;
            s1_zp_r    <= '0;
        end else if (en_s) begin
            s1_data_r  <= in_data;
            s1_ch_r    <= in_ch;
            s1_mult_r  <= mult_tab_r[rd_idx_s];
            s1_shift_r <= shift_tab_r[rd_idx_s];
            s1_zp_r    <= zp_tab_r[rd_idx_s];
        end
    end

    // Signed product. The multiplier is treated as a non-negative value.
    always_comb begin
        prod_s = PW'(s1_data_r) * PW'($signed({1'b0, s1_mult_r}));
    end

    // Stage 2: register the product and carry the remaining parameters along.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_prod_r  <= '0;
            s2_ch_r    <= '0;
            s2_shift_r <= '0;
            s2_zp_r    <= '0;
        end else if (en_s) begin
            s2_prod_r  <= prod_s;
            s2_ch_r    <= s1_ch_r;
            s2_shift_r <= s1_shift_r;
            s2_zp_r    <= s1_zp_r;
        end
    end

    // Round half up (optional), floor-shift, add zero point, then clip.
    always_comb begin
        rnd_s      = '0;
        sat_data_s = '0;
        sat_s      = 1'b0;
        if ((ROUND != 0) && (s2_shift_r != '0)) begin
            rnd_s = {{(RW-1){1'b0}}, 1'b1} << (s2_shift_r - {{(SHIFT_W-1){1'b0}}, 1'b1});
        end else begin
            rnd_s = '0;
        end
        sum_s = RW'(s2_prod_r) + rnd_s;
        shr_s = sum_s >>> s2_shift_r;
        q_s   = QW'(shr_s) + QW'($signed({1'b0, s2_zp_r}));
        if (q_s[QW-1]) begin
            sat_data_s = '0;
            sat_s      = 1'b1;
        end else if (|q_s[QW-2:OUT_W]) begin
            sat_data_s = '1;
            sat_s      = 1'b1;
        end else begin
            sat_data_s = q_s[OUT_W-1:0];
            sat_s      = 1'b0;
        end
    end

    // Stage 3: load the output register only with real beats. The held
    // value stays stable while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r <= '0;
            out_ch_r   <= '0;
            out_sat_r  <= 1'b0;
        end else if (en_s && s2_valid_r) begin
            out_data_r <= sat_data_s;
            out_ch_r   <= s2_ch_r;
            out_sat_r  <= sat_s;
        end
    end

    // Clip counter. It sticks at all-ones, and a clear overrides a clip
    // that arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count_r <= '0;
        end else if (sat_clr) begin
            sat_count_r <= '0;
        end else if (en_s && s2_valid_r && sat_s && (sat_count_r != '1)) begin
            sat_count_r <= sat_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_requantize_pipe.sv
// Directed testbench for requantize_pipe. The main instance rounds and has a
// 4-bit clip counter. A second instance shares all inputs and truncates.
module tb_requantize_pipe;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [31:0] in_data;
    logic [1:0]         in_ch;
    logic               out_ready;
    logic               cfg_we;
    logic [1:0]         cfg_ch;
    logic [31:0]        cfg_mult;
    logic [5:0]         cfg_shift;
    logic [7:0]         cfg_zp;
    logic               sat_clr;

    logic               in_ready, out_valid, out_sat;
    logic [7:0]         out_data;
    logic [1:0]         out_ch;
    logic [3:0]         sat_count;

    logic               t_in_ready, t_out_valid, t_out_sat;
    logic [7:0]         t_out_data;
    logic [1:0]         t_out_ch;
    logic [15:0]        t_sat_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    requantize_pipe #(.CHANNELS(3), .ROUND(1), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ch(in_ch), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .out_sat(out_sat), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
        .sat_clr(sat_clr), .sat_count(sat_count)
    );

    requantize_pipe #(.CHANNELS(3), .ROUND(0)) dut_trunc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
        .in_data(in_data), .in_ch(in_ch), .out_valid(t_out_valid),
        .out_ready(out_ready), .out_data(t_out_data), .out_ch(t_out_ch),
        .out_sat(t_out_sat), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
        .sat_clr(sat_clr), .sat_count(t_sat_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [31:0] m, input logic [5:0] s, input logic [7:0] z);
        cfg_we = 1'b1; cfg_ch = ch; cfg_mult = m; cfg_shift = s; cfg_zp = z;
        tick;
        cfg_we = 1'b0;
    endtask

    // Wait (bounded) for an output beat, check it, then let it drain.
    task automatic collect(input logic [7:0] exp_d, input logic [1:0] exp_ch, input logic exp_s, input string tag);
        int n = 0;
        while (!out_valid && n < 10) begin
            tick;
            n++;
        end
        check_val({tag, "_valid"}, out_valid, 1);
        check_val({tag, "_data"}, out_data, exp_d);
        check_val({tag, "_ch"}, out_ch, exp_ch);
        check_val({tag, "_sat"}, out_sat, exp_s);
        tick;
    endtask

    // Send a lone beat and check its result and its 3-edge latency.
    task automatic send_one(input logic [1:0] ch, input int data, input logic [7:0] exp_d, input logic exp_s, input string tag);
        int n = 1;
        in_valid = 1'b1; in_ch = ch; in_data = data;
        tick;
        in_valid = 1'b0;
        while (!out_valid && n < 10) begin
            tick;
            n++;
        end
        check_val({tag, "_lat"}, n, 3);
        check_val({tag, "_data"}, out_data, exp_d);
        check_val({tag, "_sat"}, out_sat, exp_s);
        check_val({tag, "_ch"}, out_ch, ch);
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, recv, first_out;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ch = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_ch = '0; cfg_mult = '0; cfg_shift = '0; cfg_zp = '0; sat_clr = 1'b0;
        repeat (3) tick;
        rst = 1'b0;

        // Reset state
        check_val("rst_valid", out_valid, 0);
        check_val("rst_data", out_data, 0);
        check_val("rst_ch", out_ch, 0);
        check_val("rst_sat", out_sat, 0);
        check_val("rst_cnt", sat_count, 0);
        check_val("rst_inrdy", in_ready, 1);

        // Rounding and zero point: scale 0.5, so R = round(x/2)
        cfg(2'd0, 32'h4000_0000, 6'd31, 8'd0);
        send_one(2'd0, 5, 8'd3, 1'b0, "rnd_p5");
        check_val("trunc_p5", t_out_data, 2);
        check_val("trunc_p5_sat", t_out_sat, 0);
        send_one(2'd0, -5, 8'd0, 1'b1, "rnd_m5");
        send_one(2'd0, 4, 8'd2, 1'b0, "rnd_p4");
        cfg(2'd0, 32'h4000_0000, 6'd31, 8'd10);
        send_one(2'd0, -5, 8'd8, 1'b0, "zp_m5");
        check_val("cnt_one", sat_count, 1);

        // Saturation in both directions, counter, and clear priority
        cfg(2'd0, 32'h4000_0000, 6'd31, 8'd0);
        sat_clr = 1'b1; tick; sat_clr = 1'b0;
        check_val("cnt_clr", sat_count, 0);
        send_one(2'd0, 1000, 8'd255, 1'b1, "sat_hi");
        send_one(2'd0, -100, 8'd0, 1'b1, "sat_lo");
        check_val("cnt_two", sat_count, 2);
        in_valid = 1'b1; in_ch = 2'd0; in_data = 1000;
        tick;
        in_valid = 1'b0;
        tick;
        sat_clr = 1'b1;
        tick;
        sat_clr = 1'b0;
        check_val("clrprio_valid", out_valid, 1);
        check_val("clrprio_data", out_data, 255);
        check_val("clrprio_cnt", sat_count, 0);
        tick;

        // Per-channel parameters; channel 3 does not exist, so it maps to entry 0
        cfg(2'd1, 32'h8000_0000, 6'd31, 8'd3);
        cfg(2'd3, 32'h8000_0000, 6'd0, 8'd50);
        in_valid = 1'b1;
        in_ch = 2'd0; in_data = 10; tick;
        in_ch = 2'd1; in_data = 10; tick;
        in_ch = 2'd3; in_data = 10; tick;
        in_valid = 1'b0;
        collect(8'd5, 2'd0, 1'b0, "pc_ch0");
        collect(8'd13, 2'd1, 1'b0, "pc_ch1");
        collect(8'd5, 2'd3, 1'b0, "pc_ch3");

        // A write in the same cycle as a beat does not affect that beat
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_mult = 32'h8000_0000; cfg_shift = 6'd31; cfg_zp = 8'd7;
        in_valid = 1'b1; in_ch = 2'd1; in_data = 10;
        tick;
        cfg_we = 1'b0;
        tick;
        in_valid = 1'b0;
        collect(8'd13, 2'd1, 1'b0, "col_old");
        collect(8'd17, 2'd1, 1'b0, "col_new");

        // Backpressure: 8 beats with a 5-cycle stall partway through
        sent = 0; recv = 0; first_out = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = (cyc >= 5 && cyc < 10) ? 1'b0 : 1'b1;
            in_valid  = (sent < 8);
            in_ch     = 2'd1;
            in_data   = sent * 3;
            #1;
            if (out_valid) begin
                if (first_out < 0) first_out = cyc;
                check_val("bp_data", out_data, 8'(recv * 3 + 7));
                check_val("bp_ch", out_ch, 1);
                if (!out_ready) check_val("bp_inrdy", in_ready, 0);
                if (out_ready) recv++;
            end
            if (in_valid && in_ready) sent++;
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check_val("bp_count", recv, 8);
        check_val("bp_first", first_out, 3);

        // Reset mid-stream
        in_valid = 1'b1; in_ch = 2'd1; in_data = 50;
        repeat (3) tick;
        in_valid = 1'b0; rst = 1'b1;
        tick;
        rst = 1'b0;
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_cnt", sat_count, 0);
        for (int k = 0; k < 5; k++) begin
            check_val("mid_rst_stale", out_valid, 0);
            tick;
        end
        send_one(2'd1, 50, 8'd0, 1'b0, "mid_rst_dflt");

        // Counter limit: 20 clipped beats on a 4-bit counter
        cfg(2'd0, 32'h4000_0000, 6'd31, 8'd0);
        in_valid = 1'b1; in_ch = 2'd0; in_data = 1000;
        repeat (20) tick;
        in_valid = 1'b0;
        repeat (4) tick;
        check_val("cnt_limit", sat_count, 15);
        check_val("cnt_trunc", t_sat_count, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
